// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: the received byte, its
// valid/ack handshake and the error/status flags.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 framing_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data_out, rx_valid, framing_err, overrun, busy,
    input  rx_ack
  );

  modport slave (
    input  data_out, rx_valid, framing_err, overrun, busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling with 2-of-3 majority per bit, a
// valid/ack holding register for the received byte, and framing/overrun flags.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      baud16x_tick,
  input  logic      rx,
  uart_rx_if.master rx_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_q, overrun_d;

  logic rxs;
  logic maj;
  logic accept;

  assign rxs = sync_q[1];
  // samp_q[1] holds the tick-7 sample, samp_q[0] the tick-8 sample; rxs is tick 9.
  assign maj = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);

  always_comb begin
    sync_d        = {sync_q[0], rx};
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    samp_d        = samp_q;
    shift_reg_d   = shift_reg_q;
    accept        = 1'b0;
    framing_err_d = 1'b0;

    if (baud16x_tick) begin
      // tick_cnt_q is the slot position of the tick now arriving.
      if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd7) samp_d[1] = rxs;
        if (tick_cnt_q == 4'd8) samp_d[0] = rxs;
      end

      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            // The detecting tick is tick 0 of the start bit.
            state_d    = S_START;
            tick_cnt_d = 4'd1;
          end
        end
        S_START: begin
          if (tick_cnt_q == 4'd9 && maj) begin
            state_d = S_IDLE;
          end else if (tick_cnt_q == 4'd15) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          if (tick_cnt_q == 4'd9) shift_reg_d = {maj, shift_reg_q[DATA_BITS-1:1]};
          if (tick_cnt_q == 4'd15) begin
            if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
            else                       bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_STOP: begin
          if (tick_cnt_q == 4'd9) begin
            if (maj) begin
              accept  = 1'b1;
              state_d = S_IDLE;
            end else begin
              framing_err_d = 1'b1;
              state_d       = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake runs every clock, independent of the tick.
  always_comb begin
    data_out_d = data_out_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (accept) begin
      data_out_d = shift_reg_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q & ~rx_if.rx_ack;
    end else if (rx_if.rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync_q        <= 2'b11;
      tick_cnt_q    <= 4'd0;
      bit_cnt_q     <= 3'd0;
      samp_q        <= 2'b11;
      shift_reg_q   <= '0;
      data_out_q    <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      samp_q        <= samp_d;
      shift_reg_q   <= shift_reg_d;
      data_out_q    <= data_out_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_if.data_out    = data_out_q;
  assign rx_if.rx_valid    = rx_valid_q;
  assign rx_if.framing_err = framing_err_q;
  assign rx_if.overrun     = overrun_q;
  assign rx_if.busy        = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART datapath. It oversamples the asynchronous `rx` line using the 16x-baud tick from the baud generator and decodes 8N1 frames (LSB first) with majority-vote sampling. Accepted bytes go to a valid/ack holding register, and framing and overrun events are flagged. It sits between the board RX pin and the receive-side consumer (FIFO or command parser) and runs on the same clock as the baud generator.

## Interface
- `DATA_BITS`, 8: data bits per frame. The spec, tests and port widths assume 8.
- `clk` input 1: system clock (7.3728 or 11.0592 MHz).
- `rst` input 1: reset, synchronous, active-high.
- `baud16x_tick` input 1: single-cycle pulse at 16x the baud rate.
- `rx` input 1: asynchronous serial line; idles high.
- `rx_ack` input 1: consumer has taken `data_out`; sampled every cycle.
- `data_out` output 8: last accepted byte.
- `rx_valid` output 1: `data_out` holds an unacknowledged byte.
- `framing_err` output 1: one-cycle pulse when the stop bit samples low.
- `overrun` output 1: one-cycle pulse when an unacked byte is overwritten.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- **Tick gating.** `tick_cnt` (4 bits), `bit_cnt` (3 bits), sampling and state changes advance only on cycles where `baud16x_tick` = 1. The handshake logic runs every cycle.
- **Majority sampling.** Every bit slot is 16 ticks, `tick_cnt` 0..15. `rxs` is sampled at `tick_cnt` 7, 8 and 9, and the bit value is the 2-of-3 majority, resolved at tick 9.
- **IDLE.** On a tick with `rxs` = 0, go to START with `tick_cnt` = 0; that tick counts as tick 0.
- **START.** At tick 9: majority 1 means a false start, so go to IDLE. Majority 0 means continue. At tick 15, go to DATA with `tick_cnt` = 0 and `bit_cnt` = 0.
- **DATA.** At tick 9, shift the majority value into the MSB of `shift_reg` (right shift, so the LSB arrives first). At tick 15: if `bit_cnt` = 7, go to STOP; otherwise increment `bit_cnt`.
- **STOP, resolved at tick 9.**
  - Majority 1: load `data_out` from `shift_reg`, set `rx_valid`, go to IDLE. Leaving at mid-stop-bit allows resync on the next start edge.
  - Majority 0: pulse `framing_err`, leave `data_out` and `rx_valid` unchanged, go to BREAK.
- **BREAK.** Stay until a tick with `rxs` = 1, then go to IDLE. A held-low line never produces frames.
- **Handshake.**
  - `rx_valid` clears on any cycle with `rx_ack` = 1 and no byte accepted in that cycle.
  - Byte accepted while `rx_valid` = 1 and `rx_ack` = 0: `data_out` is overwritten, `rx_valid` stays 1, `overrun` pulses.
  - Byte accepted in the same cycle as `rx_ack` = 1: the new byte loads, `rx_valid` stays 1, no `overrun`.
  - `rx_ack` while `rx_valid` = 0 has no effect.
- **Reset.** Reset in any state, including mid-frame, aborts the frame: go to IDLE and clear the counters and `shift_reg`.

## Timing
- **Reset values:** `data_out` = 0x00, `rx_valid` = 0, `framing_err` = 0, `overrun` = 0, `busy` = 0, state IDLE, synchronizer flops = 1.
- **`rx` to `rxs` latency:** 2 clk.
- **Start edge to detection:** at most one tick period plus 2 clk.
- **Output update:** `rx_valid` rises, `data_out` updates and `framing_err`/`overrun` pulse 1 clk after the stop-bit tick-9 cycle (registered outputs).
- **Frame length** from detected start tick to `rx_valid`: 9×16 + 10 = 154 ticks.
- **Back-to-back frames:** a new start bit is accepted on the first tick after returning to IDLE. Minimum line gap: the remainder of the stop bit.
- **Ack:** `rx_valid` falls 1 clk after the `rx_ack` cycle.
- **Pulse width:** `framing_err` and `overrun` are exactly one clk wide.

## Test plan
Clk 11.0592 MHz, `baud16x_tick` every 6 clk (115200 baud, 96 clk per bit), unless a test says otherwise.

1. **Clean frame.** Drive 0x55 as 8N1, then ack 5 clk after `rx_valid`. Required: `rx_valid` = 1 with `data_out` = 0x55, `framing_err` = 0, `overrun` = 0; `rx_valid` = 0 1 clk after `rx_ack`; `busy` = 0 after stop-bit tick 9.
2. **Glitch and noise rejection.**
   - Drive `rx` low for 3 ticks, then high. Required: return to IDLE at START tick 9, no `rx_valid`.
   - Send 0xA5 with a 1-tick low glitch at tick 8 of data bit 0. Required: `data_out` = 0xA5.
3. **Framing and break.** Send 0xA3 with stop bit 0, then hold `rx` low for 3 bit-times, then idle high and send 0x3C. Required: `framing_err` pulses exactly once, `rx_valid` stays 0, nothing is received during the low period, then `data_out` = 0x3C with `rx_valid` = 1.
4. **Overrun.** Send 0x12 then 0x34 back-to-back with no ack. Required: `overrun` pulses once at the second byte, `data_out` = 0x34, `rx_valid` = 1.
5. **Simultaneous ack and accept.** Repeat test 4 but assert `rx_ack` in the cycle the second byte is accepted. Required: no `overrun`, `data_out` = 0x34, `rx_valid` = 1.
6. **Reset mid-frame.** Assert `rst` for 1 clk during data bit 4 of 0xFF. Required: all outputs at reset values and `busy` = 0 the next clk; the next full frame 0x81 is received with `data_out` = 0x81. Also repeat test 1 at a tick every 72 clk (9600 baud): 0x55 received.
